// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/PC-enable feedback for the F/D, D/E and E/M latches.
// Define HAZARD_PERF_CNT_EN to add stall/flush/load-use event counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned REGADDR_W        = 5
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 ihit,
  input  logic                 dhit,
  input  logic [REGADDR_W-1:0] de_rs,
  input  logic [REGADDR_W-1:0] de_rt,
  input  logic                 de_uses_rt,
  input  logic [REGADDR_W-1:0] ex_wsel,
  input  logic                 ex_RegWrite,
  input  logic                 ex_dREN,
  input  logic                 ex_pcsrc,
  input  logic                 ex_halt,
  input  logic                 mem_dREN,
  input  logic                 mem_dWEN,
  output logic                 pc_en,
  output logic                 stall_fd,
  output logic                 flush_fd,
  output logic                 stall_de,
  output logic                 flush_de,
  output logic                 stall_em,
  output logic                 halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events,
  output logic [31:0]          lu_events
`endif
);

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT,
    HALTED
  } state_e;

  localparam logic [1:0] LuInit =
    2'(LOAD_USE_BUBBLES - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mem_busy, lu_hazard, in_lu;
  logic       pc_en_c, sfd_c, ffd_c;
  logic       sde_c, fde_c, sem_c, hlt_c;

  assign mem_busy = (mem_dREN | mem_dWEN) & ~dhit;

  assign lu_hazard = ex_dREN & ex_RegWrite
    & (ex_wsel != '0)
    & ((ex_wsel == de_rs)
       | (de_uses_rt & (ex_wsel == de_rt)));

  // MEM_WAIT resumes the context the bubble counter implies
  assign in_lu = (state_q == LU_STALL)
    | ((state_q == MEM_WAIT) & (cnt_q != 2'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_en_c = 1'b0;
    sfd_c   = 1'b0;
    ffd_c   = 1'b0;
    sde_c   = 1'b0;
    fde_c   = 1'b0;
    sem_c   = 1'b0;
    hlt_c   = 1'b0;
    priority case (1'b1)
      (state_q == HALTED): begin
        sfd_c = 1'b1;
        sde_c = 1'b1;
        sem_c = 1'b1;
        hlt_c = 1'b1;
      end
      mem_busy: begin
        sfd_c   = 1'b1;
        sde_c   = 1'b1;
        sem_c   = 1'b1;
        state_d = MEM_WAIT;
      end
      ex_halt: begin
        ffd_c   = 1'b1;
        fde_c   = 1'b1;
        cnt_d   = 2'd0;
        state_d = HALTED;
      end
      ex_pcsrc: begin
        ffd_c   = 1'b1;
        fde_c   = 1'b1;
        pc_en_c = 1'b1;
        cnt_d   = 2'd0;
        state_d = RUN;
      end
      in_lu: begin
        sfd_c   = 1'b1;
        fde_c   = 1'b1;
        cnt_d   = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd1) ? RUN : LU_STALL;
      end
      lu_hazard: begin
        sfd_c   = 1'b1;
        fde_c   = 1'b1;
        cnt_d   = LuInit;
        state_d = (LuInit != 2'd0) ? LU_STALL : RUN;
      end
      ~ihit: begin
        sfd_c   = 1'b1;
        fde_c   = 1'b1;
        state_d = RUN;
      end
      default: begin
        pc_en_c = 1'b1;
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_en    = nRST & pc_en_c;
  assign stall_fd = nRST & sfd_c;
  assign flush_fd = nRST & ffd_c;
  assign stall_de = nRST & sde_c;
  assign flush_de = nRST & fde_c;
  assign stall_em = nRST & sem_c;
  assign halted   = nRST & hlt_c;

`ifdef HAZARD_PERF_CNT_EN
  logic live, fl_ev, lu_ev;

  assign live  = (state_q != HALTED);
  assign fl_ev = fde_c & (ex_halt | ex_pcsrc);
  assign lu_ev = fde_c & lu_hazard & ~in_lu
    & ~ex_halt & ~ex_pcsrc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_events <= '0;
      lu_events    <= '0;
    end else if (live) begin
      if (!pc_en_c) stall_cycles <= stall_cycles + 32'd1;
      if (fl_ev)    flush_events <= flush_events + 32'd1;
      if (lu_ev)    lu_events    <= lu_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Feedback-direction controller for the decode/execute pipeline latch and its neighbours.
- Consumes hazard information from the decode, execute and memory stages.
- Drives the stall, flush and PC-enable controls back into the fetch/decode, decode/execute and execute/memory latches and the PC.
- Owns load-use bubble insertion, memory-wait freeze, branch/jump redirect flush and the terminal halt state.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3); 1 with memory-stage forwarding, 2 without.
- REGADDR_W, 5, register index width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- de_rs  in  REGADDR_W  decode-stage source register 1
- de_rt  in  REGADDR_W  decode-stage source register 2
- de_uses_rt  in  1  decode instruction reads rt
- ex_wsel  in  REGADDR_W  execute-stage destination register
- ex_RegWrite  in  1  execute instruction writes a register
- ex_dREN  in  1  execute instruction is a load
- ex_pcsrc  in  1  execute-stage branch taken, jump, jr or jal
- ex_halt  in  1  halt instruction in execute
- mem_dREN  in  1  memory-stage read pending
- mem_dWEN  in  1  memory-stage write pending
- pc_en  out  1  PC may update
- stall_fd  out  1  hold fetch/decode latch
- flush_fd  out  1  clear fetch/decode latch
- stall_de  out  1  hold decode/execute latch (drives its stall input)
- flush_de  out  1  bubble into decode/execute latch (drives its flush input)
- stall_em  out  1  hold execute/memory latch
- halted  out  1  core in terminal halt state

Behaviour:
- Outputs are combinational from state plus inputs. All state is updated on posedge CLK.
- nRST low gives state RUN and bubble counter 0, asynchronously. While nRST is low, every output is 0.
- States:
  - RUN: normal operation.
  - LU_STALL: load-use bubbles in progress.
  - MEM_WAIT: data access outstanding.
  - HALTED: terminal.
- Derived signals:
  - mem_busy = (mem_dREN | mem_dWEN) & ~dhit.
  - lu_hazard = ex_dREN & ex_RegWrite & (ex_wsel != 0) & ((ex_wsel == de_rs) | (de_uses_rt & ex_wsel == de_rt)).
- Per-cycle priority, highest first:
  1. HALTED: pc_en=0, stall_fd=1, stall_de=1, stall_em=1, halted=1, flush_*=0. Only reset exits.
  2. mem_busy (any non-halted state):
     - stall_fd=1, stall_de=1, stall_em=1, pc_en=0, flush_*=0.
     - Next state MEM_WAIT. The bubble counter holds its value.
     - MEM_WAIT returns to the saved context (LU_STALL if counter ≠ 0, else RUN) on the cycle mem_busy falls.
  3. ex_halt:
     - flush_fd=1, flush_de=1, pc_en=0.
     - Next state HALTED. Any pending bubbles are discarded.
  4. ex_pcsrc:
     - flush_fd=1, flush_de=1, pc_en=1 (redirect).
     - Overrides load-use, because the decode instruction is wrong-path. Clears the bubble counter; next state RUN.
  5. LU_STALL, or RUN with lu_hazard:
     - stall_fd=1, flush_de=1, pc_en=0.
     - In RUN, lu_hazard loads the counter with LOAD_USE_BUBBLES-1 and moves to LU_STALL if that value is nonzero; otherwise stays in RUN.
     - In LU_STALL, the counter decrements; reaching 0 returns to RUN.
     - ex_* comparisons are ignored while in LU_STALL.
  6. ~ihit: stall_fd=1, flush_de=1, pc_en=0.
  7. Otherwise: pc_en=1, all stalls and flushes 0.
- stall_x and flush_x are never both 1 for the same latch in the same cycle.
- A load writing register 0 never creates a hazard.
- Mid-operation reset returns to RUN with a cleared counter immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three extra outputs are added, each 32 bits and reset to 0 by nRST:
  - stall_cycles: increments every cycle pc_en=0 while not HALTED.
  - flush_events: increments every cycle flush_de=1 caused by ex_pcsrc or ex_halt.
  - lu_events: increments once per load-use hazard detection in RUN.
- All three counters wrap modulo 2^32 and freeze in HALTED.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Load-use, LOAD_USE_BUBBLES=1:
  - Stimulus: ex_dREN=1, ex_RegWrite=1, ex_wsel=8, de_rs=8, ihit=1.
  - Response: one cycle with stall_fd=1, flush_de=1, pc_en=0, then pc_en=1.
  - Repeat with ex_wsel=0: no stall.
- LOAD_USE_BUBBLES=2 with de_rt=9, de_uses_rt=1, ex_wsel=9: exactly 2 consecutive bubble cycles. With de_uses_rt=0: none.
- Memory wait:
  - Stimulus: mem_dREN=1, dhit=0 for 4 cycles, then dhit=1.
  - Response: stall_fd, stall_de and stall_em all 1 with pc_en=0 for 4 cycles; pc_en=1 on the dhit cycle.
  - Repeat with mem_dREN asserted during LU_STALL (LOAD_USE_BUBBLES=3): counter resumes afterward, for 3 total bubble cycles.
- Branch during load-use:
  - Stimulus: ex_pcsrc=1 together with lu_hazard.
  - Response: flush_fd=1, flush_de=1, pc_en=1, stall_fd=0; next cycle no bubble.
- Halt:
  - Stimulus: ex_halt=1.
  - Response: one flush cycle, then halted=1 and pc_en=0 permanently, ignoring ex_pcsrc=1 and mem_busy.
  - Asserting nRST=0 clears halted asynchronously.
- With HAZARD_PERF_CNT_EN defined: after scenarios 1 (first part only) and 4, stall_cycles=1, flush_events=1, lu_events=1.
